// File: rtl/ksa_pkg.sv
// Shared types and helpers for the Kogge-Stone adder.
// Provides the (g,p) pair, prefix-level count and prefix operator.
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // ceil(log2(n+1)): the tree spans n bit positions plus the carry-in slot
    function automatic int ksa_levels(input int n);
        int l;
        l = 0;
        while ((1 << l) < n + 1) begin
            l++;
        end
        return l;
    endfunction

    // (G,P) o (G',P') = (G | P&G', P&P')
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ksa_pg_cell.sv
// One black cell of the prefix tree: gp_o = hi_i o lo_i.
// Ports: hi_i (higher position), lo_i (lower position), gp_o (result).
module ksa_pg_cell
    import ksa_pkg::*;
(
    input  gp_t hi_i,
    input  gp_t lo_i,
    output gp_t gp_o
);

    assign gp_o = gp_combine(hi_i, lo_i);

endmodule

// File: rtl/ksa.sv
// N-bit Kogge-Stone adder, {cout,s} = a + b + cin, plus registered copies.
// Ports: clk, reset_n (async low), a, b, cin -> s, cout, s_q, cout_q;
// ovf / ovf_q (signed overflow) exist only when KSA_OVF_EN is defined.
module ksa
    import ksa_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic [N-1:0] s_q,
`ifdef KSA_OVF_EN
    output logic         cout_q,
    output logic         ovf,
    output logic         ovf_q
`else
    output logic         cout_q
`endif
);

    localparam int L = ksa_levels(N);

    // Index j holds bit position j-1; index 0 is the carry-in slot.
    gp_t          pre [N+1];
    logic [N-1:0] p_bit;
    logic [N:0]   c;
    logic [N-1:0] s_d;
    logic         cout_d;

    always_comb begin
        pre[0].g = cin;
        pre[0].p = 1'b0;
        p_bit    = '0;
        for (int i = 0; i < N; i++) begin
            pre[i+1].g = a[i] & b[i];
            pre[i+1].p = a[i] ^ b[i];
            p_bit[i]   = a[i] ^ b[i];
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        gp_t src [N+1];
        gp_t row [N+1];
        if (k == 0) begin : g_first
            assign src = pre;
        end else begin : g_next
            assign src = g_lvl[k-1].row;
        end
        for (genvar j = 0; j <= N; j++) begin : g_pos
            if (j >= (1 << k)) begin : g_cell
                ksa_pg_cell u_cell (
                    .hi_i (src[j]),
                    .lo_i (src[j-(1<<k)]),
                    .gp_o (row[j])
                );
            end else begin : g_pass
                assign row[j] = src[j];
            end
        end
    end

    // After the last level, group G at index j is the carry into bit j.
    always_comb begin
        c = '0;
        for (int j = 0; j <= N; j++) begin
            c[j] = g_lvl[L-1].row[j].g;
        end
    end

    always_comb begin
        s      = p_bit ^ c[N-1:0];
        cout   = c[N];
        s_d    = s;
        cout_d = cout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

`ifdef KSA_OVF_EN
    logic ovf_d;

    always_comb begin
        ovf   = c[N] ^ c[N-1];
        ovf_d = ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa at N = 4, 7, 16 and 64.
// Registered results are checked through an expected-value queue.
module tb_ksa;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [3:0]  a4, b4, s4, s4_q;
    logic        cin4, co4, co4_q;
    logic [6:0]  a7, b7, s7, s7_q;
    logic        cin7, co7, co7_q;
    logic [15:0] a16, b16, s16, s16_q;
    logic        cin16, co16, co16_q;
    logic [63:0] a64, b64, s64, s64_q;
    logic        cin64, co64, co64_q;

`ifdef KSA_OVF_EN
    logic ov4, ov4_q, ov7, ov7_q, ov16, ov16_q, ov64, ov64_q;
`endif

    int total = 0;
    int bad   = 0;

    logic [4:0] sb_q [$];

    ksa #(.N(4)) u4 (
        .clk(clk), .reset_n(reset_n), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(co4), .s_q(s4_q),
`ifdef KSA_OVF_EN
        .cout_q(co4_q), .ovf(ov4), .ovf_q(ov4_q)
`else
        .cout_q(co4_q)
`endif
    );

    ksa #(.N(7)) u7 (
        .clk(clk), .reset_n(reset_n), .a(a7), .b(b7), .cin(cin7),
        .s(s7), .cout(co7), .s_q(s7_q),
`ifdef KSA_OVF_EN
        .cout_q(co7_q), .ovf(ov7), .ovf_q(ov7_q)
`else
        .cout_q(co7_q)
`endif
    );

    ksa #(.N(16)) u16 (
        .clk(clk), .reset_n(reset_n), .a(a16), .b(b16), .cin(cin16),
        .s(s16), .cout(co16), .s_q(s16_q),
`ifdef KSA_OVF_EN
        .cout_q(co16_q), .ovf(ov16), .ovf_q(ov16_q)
`else
        .cout_q(co16_q)
`endif
    );

    ksa #(.N(64)) u64 (
        .clk(clk), .reset_n(reset_n), .a(a64), .b(b64), .cin(cin64),
        .s(s64), .cout(co64), .s_q(s64_q),
`ifdef KSA_OVF_EN
        .cout_q(co64_q), .ovf(ov64), .ovf_q(ov64_q)
`else
        .cout_q(co64_q)
`endif
    );

    task automatic test_reset();
        reset_n = 1'b1;
        a4 = 4'd9; b4 = 4'd9; cin4 = 1'b1;
        a7 = '0; b7 = '0; cin7 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;
        a64 = '0; b64 = '0; cin64 = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({co4_q, s4_q} !== 5'b0) begin
            bad++;
            $display("FAIL reset_q got=%b want=00000", {co4_q, s4_q});
        end
        total++;
        if ({co4, s4} !== 5'b10011) begin
            bad++;
            $display("FAIL reset_comb got=%b want=10011", {co4, s4});
        end
`ifdef KSA_OVF_EN
        total++;
        if (ov4_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf_q got=%b want=0", ov4_q);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [4:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [4];
        logic [4:0] e;
        tbl[0] = '{4'b0101, 4'b0011, 1'b0, 5'b01000};
        tbl[1] = '{4'b1111, 4'b0001, 1'b0, 5'b10000};
        tbl[2] = '{4'b1111, 4'b1111, 1'b1, 5'b11111};
        tbl[3] = '{4'b0000, 4'b0000, 1'b1, 5'b00001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = tbl[i].a; b4 = tbl[i].b; cin4 = tbl[i].ci;
            sb_q.push_back(tbl[i].exp);
            #1;
            total++;
            if ({co4, s4} !== tbl[i].exp) begin
                bad++;
                $display("FAIL directed%0d got=%b want=%b",
                         i, {co4, s4}, tbl[i].exp);
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            total++;
            if ({co4_q, s4_q} !== e) begin
                bad++;
                $display("FAIL directed_q%0d got=%b want=%b",
                         i, {co4_q, s4_q}, e);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] e;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c);
                    e = 5'(x + y + c);
                    #1;
                    total++;
                    if ({co4, s4} !== e) begin
                        bad++;
                        $display("FAIL exh a=%0d b=%0d c=%0d got=%b want=%b",
                                 x, y, c, {co4, s4}, e);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  e7;
        logic [16:0] e16;
        logic [64:0] e64;
        for (int i = 0; i < 200; i++) begin
            a7 = 7'($urandom); b7 = 7'($urandom); cin7 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            cin64 = 1'($urandom);
            if (i == 0) begin
                a64 = '1; b64 = '0; cin64 = 1'b1;
                a7 = '1; b7 = '1; cin7 = 1'b1;
            end
            e7  = {1'b0, a7} + {1'b0, b7} + 8'(cin7);
            e16 = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
            e64 = {1'b0, a64} + {1'b0, b64} + 65'(cin64);
            #1;
            total++;
            if ({co7, s7} !== e7) begin
                bad++;
                $display("FAIL rand7 got=%h want=%h", {co7, s7}, e7);
            end
            total++;
            if ({co16, s16} !== e16) begin
                bad++;
                $display("FAIL rand16 got=%h want=%h", {co16, s16}, e16);
            end
            total++;
            if ({co64, s64} !== e64) begin
                bad++;
                $display("FAIL rand64 got=%h want=%h", {co64, s64}, e64);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            sb_q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
            @(posedge clk);
            #1;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL b2b_empty got=0 want=1");
            end else begin
                e = sb_q.pop_front();
                if ({co4_q, s4_q} !== e) begin
                    bad++;
                    $display("FAIL b2b%0d got=%b want=%b",
                             i, {co4_q, s4_q}, e);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a4 = 4'b0110; b4 = 4'b0100; cin4 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({co4_q, s4_q} !== 5'b01010) begin
            bad++;
            $display("FAIL mid_pre got=%b want=01010", {co4_q, s4_q});
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({co4_q, s4_q} !== 5'b0) begin
            bad++;
            $display("FAIL mid_clear got=%b want=00000", {co4_q, s4_q});
        end
        total++;
        if ({co4, s4} !== 5'b01010) begin
            bad++;
            $display("FAIL mid_comb got=%b want=01010", {co4, s4});
        end
        a4 = 4'b0001; b4 = 4'b0001;
        #1;
        total++;
        if ({co4, s4} !== 5'b00010) begin
            bad++;
            $display("FAIL mid_track got=%b want=00010", {co4, s4});
        end
        @(posedge clk);
        #1;
        total++;
        if ({co4_q, s4_q} !== 5'b0) begin
            bad++;
            $display("FAIL mid_hold got=%b want=00000", {co4_q, s4_q});
        end
        @(negedge clk);
        reset_n = 1'b1;
        a4 = 4'b0011; b4 = 4'b0100;
        @(posedge clk);
        #1;
        total++;
        if ({co4_q, s4_q} !== 5'b00111) begin
            bad++;
            $display("FAIL mid_release got=%b want=00111", {co4_q, s4_q});
        end
    endtask

`ifdef KSA_OVF_EN
    task automatic test_ovf();
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic       te [3];
        ta[0] = 4'b0111; tb[0] = 4'b0001; te[0] = 1'b1;
        ta[1] = 4'b1000; tb[1] = 4'b1111; te[1] = 1'b1;
        ta[2] = 4'b0011; tb[2] = 4'b0010; te[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = ta[i]; b4 = tb[i]; cin4 = 1'b0;
            #1;
            total++;
            if (ov4 !== te[i]) begin
                bad++;
                $display("FAIL ovf%0d got=%b want=%b", i, ov4, te[i]);
            end
            @(posedge clk);
            #1;
            total++;
            if (ov4_q !== te[i]) begin
                bad++;
                $display("FAIL ovf_q%0d got=%b want=%b", i, ov4_q, te[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_random();
        test_back_to_back();
        test_reset_midstream();
`ifdef KSA_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
